// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load, clear, logical/arithmetic shifts
// and rotates by a multi-cycle count, one bit per clock, with a busy/done
// handshake. Commands with amt<=1 complete at the accept edge; longer shifts
// finish their remaining steps in the SHIFT state.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;
    localparam logic [2:0] OP_ASR   = 3'b101;
    localparam logic [2:0] OP_ROL   = 3'b110;
    localparam logic [2:0] OP_ROR   = 3'b111;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic             ser_q;
    logic             done_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt_q;

    logic             is_multi;
    logic             accept;
    logic [2:0]       step_op;
    logic [WIDTH:0]   step_d;

    // One 1-bit step of a shift/rotate: returns {bit shifted out, new contents}.
    function automatic logic [WIDTH:0] shift_step(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] d,
                                                  input logic s);
        logic [WIDTH:0] r;
        case (o)
            OP_SHL:  r = {d[WIDTH-1], d[WIDTH-2:0], s};
            OP_SHR:  r = {d[0], s, d[WIDTH-1:1]};
            OP_ASR:  r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROL:  r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
            OP_ROR:  r = {d[0], d[0], d[WIDTH-1:1]};
            default: r = {1'b0, d};
        endcase
        return r;
    endfunction

    // Accept qualification and the step datapath shared by both states.
    // A command that would complete immediately is held off during the done
    // cycle so done can never be high on two consecutive cycles; a multi-cycle
    // shift may still be accepted back-to-back since its done comes later.
    always_comb begin
        is_multi = (op >= OP_SHL) && (amt > AMT_W'(1));
        accept   = start && (state_q == IDLE) && (!done_q || is_multi);
        step_op  = (state_q == SHIFT) ? op_q : op;
        step_d   = shift_step(step_op, data_q, ser_in);
    end

    // Control FSM and register state; outputs are all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            ser_q   <= 1'b0;
            done_q  <= 1'b0;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_NOP:   done_q <= 1'b1;
                            OP_LOAD: begin
                                data_q <= data_in;
                                done_q <= 1'b1;
                            end
                            OP_CLEAR: begin
                                data_q <= '0;
                                done_q <= 1'b1;
                            end
                            default: begin
                                if (amt == '0) begin
                                    done_q <= 1'b1;
                                end else begin
                                    {ser_q, data_q} <= step_d;
                                    cnt_q           <= amt - AMT_W'(1);
                                    op_q            <= op;
                                    if (amt == AMT_W'(1)) begin
                                        done_q <= 1'b1;
                                    end else begin
                                        state_q <= SHIFT;
                                    end
                                end
                            end
                        endcase
                    end
                end
                SHIFT: begin
                    {ser_q, data_q} <= step_d;
                    cnt_q           <= cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_out = data_q;
    assign ser_out  = ser_q;
    assign busy     = (state_q == SHIFT);
    assign done     = done_q;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; SHALL be >= 2.
REQ-002 Parameter AMT_W, default $clog2(WIDTH)+1, width of the shift-amount field.
REQ-003 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset; one clock, asynchronous, active-low.
REQ-005 start  input  1  command strobe; sampled only when busy=0.
REQ-006 op  input  3  command code, sampled with start.
REQ-007 amt  input  AMT_W  shift count, sampled with start; unsigned.
REQ-008 data_in  input  WIDTH  parallel load data.
REQ-009 ser_in  input  1  serial fill bit for SHL/SHR.
REQ-010 data_out  output  WIDTH  register contents (registered).
REQ-011 ser_out  output  1  last bit shifted or rotated out (registered).
REQ-012 busy  output  1  high while a multi-cycle shift is in progress.
REQ-013 done  output  1  single-cycle pulse marking command completion.

Function
REQ-014 op codes SHALL be decoded as follows:
- 000 NOP
- 001 LOAD (data_out<=data_in)
- 010 CLEAR (data_out<=0)
- 011 SHL (shift left, LSB<=ser_in, ser_out<=old MSB)
- 100 SHR (shift right, MSB<=ser_in, ser_out<=old LSB)
- 101 ASR (shift right, MSB kept, ser_out<=old LSB)
- 110 ROL (rotate left, ser_out<=old MSB)
- 111 ROR (rotate right, ser_out<=old LSB)
REQ-015 FSM SHALL have two states, IDLE and SHIFT; busy=1 exactly when state is SHIFT.
REQ-016 Accept: start=1 on a rising edge in IDLE; start SHALL be ignored in SHIFT, with no side effects.
REQ-017 NOP, LOAD, CLEAR, and shift ops with amt=0: effect at the accept edge; done=1 for the following cycle; state stays IDLE; data_out unchanged for NOP and amt=0; ser_out unchanged.
REQ-018 Shift op with amt>=1: first 1-bit step at the accept edge; remaining count set to amt-1.
REQ-019 amt=1: done=1 for the following cycle; state stays IDLE.
REQ-020 amt>=2: state goes to SHIFT.
REQ-021 In SHIFT, each edge SHALL apply one 1-bit step of the latched op and decrement the count.
REQ-022 On the edge applying the final step, state SHALL return to IDLE and done=1 for the following cycle; total latency amt edges, busy high amt-1 cycles.
REQ-023 op and amt SHALL be latched at accept; changes to op, amt and start during SHIFT SHALL have no effect.
REQ-024 ser_in SHALL be sampled live on every step.
REQ-025 amt > WIDTH SHALL be executed literally (amt steps): rotates wrap modulo WIDTH; SHL/SHR fill fully with ser_in; ASR saturates to the sign.
REQ-026 done SHALL never be high for two consecutive cycles.
REQ-027 A new start MAY be accepted in the same cycle that done is high.

Reset
REQ-028 rst_n=0 SHALL immediately force data_out=0, ser_out=0, busy=0, done=0, state IDLE and count 0, including mid-shift.
REQ-029 After rst_n deassertion, the first start SHALL be accepted on the next rising edge.

Verification (WIDTH=8)
REQ-030 Reset, then LOAD 0xA5 -> data_out=0xA5 one edge later; done pulses one cycle; busy stays 0.
REQ-031 data_out=0x81, SHL amt=3, ser_in=1 -> 0x03, 0x07, 0x0F on successive edges; busy high 2 cycles; done one pulse; final ser_out=0.
REQ-032 data_out=0x90, ASR amt=2 -> 0xC8 then 0xE4; ser_out=0.
REQ-033 data_out=0x3C: ROL amt=4 -> 0xC3; ROR amt=8 -> 0x3C after 8 edges, busy high 7 cycles.
REQ-034 Start with SHL amt=0 -> data_out unchanged, done pulse. start with CLEAR asserted during busy -> ignored, shift completes normally.
REQ-035 rst_n pulled low at step 2 of ROR amt=6 -> outputs zero asynchronously, no done pulse; LOAD 0x55 after release -> 0x55.
